// File: rtl/branch_resolver_pkg.sv
// Shared widths and the branch result record for the branch resolution broadcast logic.
package branch_resolver_pkg;

  localparam int NUM_BR_IN_DEF = 2;
  localparam int B_W_DEF       = 4;
  localparam int ADDR_W_DEF    = 32;

  typedef logic [B_W_DEF-1:0]    b_mask_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef struct packed {
    logic    valid;
    b_mask_t b_mm;
    b_mask_t b_mask;
    logic    mispred;
    addr_t   target;
  } br_result_t;

endpackage

// File: rtl/branch_resolver_oldest_sel.sv
// Picks the oldest mispredicting candidate: the one whose dependency mask names no
// other mispredicting candidate. The lowest slot wins if more than one qualifies.
module br_oldest_sel #(
  parameter int B_W = 4
) (
  input  logic [B_W-1:0]     mp_i,
  input  logic [B_W*B_W-1:0] dep_i,
  output logic [B_W-1:0]     oldest_o,
  output logic               found_o
);

  logic [B_W-1:0] ok_s;
  logic [B_W-1:0] others_s;
  logic           taken_s;

  // mark every mispredict candidate that depends on no other mispredict candidate
  always_comb begin
    ok_s     = {B_W{1'b0}};
    others_s = {B_W{1'b0}};
    for (int s = 0; s < B_W; s++) begin
      others_s    = mp_i;
      others_s[s] = 1'b0;
      ok_s[s]     = mp_i[s] && ((dep_i[s*B_W +: B_W] & others_s) == {B_W{1'b0}});
    end
  end

  // reduce the qualifying set to a single one-hot slot
  always_comb begin
    oldest_o = {B_W{1'b0}};
    taken_s  = 1'b0;
    for (int s = 0; s < B_W; s++) begin
      oldest_o[s] = ok_s[s] & ~taken_s;
      taken_s     = taken_s | ok_s[s];
    end
    found_o = taken_s;
  end

endmodule

// File: rtl/branch_resolver_sva.sv
// Companion checker: shadows which slots may legally be broadcast and flags
// squashed-slot broadcasts, non-one-hot mispredicts and illegal input reuse.
module branch_resolver_sva #(
  parameter int NUM_BR_IN = 2,
  parameter int B_W       = 4
) (
  input logic                     clock,
  input logic                     reset,
  input logic [NUM_BR_IN-1:0]     br_in_valid,
  input logic [NUM_BR_IN*B_W-1:0] br_in_b_mm,
  input logic [NUM_BR_IN*B_W-1:0] br_in_b_mask,
  input logic [B_W-1:0]           b_mm_resolve,
  input logic                     b_mm_mispred
);

  logic [B_W-1:0] live_q, live_d;
  logic [B_W-1:0] dep_q [B_W];
  logic [B_W-1:0] dep_d [B_W];
  logic [B_W-1:0] pend_now_s;
  logic [B_W-1:0] acc_slots_s;
  logic [B_W-1:0] seen_slots_s;
  logic [B_W-1:0] mask_v;
  logic [B_W-1:0] slot_v;
  logic           clash_s;

  // live_q is the candidate set the resolver decided on last cycle
  always_comb begin
    pend_now_s   = live_q & ~b_mm_resolve;
    acc_slots_s  = {B_W{1'b0}};
    seen_slots_s = {B_W{1'b0}};
    clash_s      = 1'b0;
    mask_v       = {B_W{1'b0}};
    slot_v       = {B_W{1'b0}};
    dep_d        = dep_q;
    for (int s = 0; s < B_W; s++) begin
      if (b_mm_mispred && ((dep_q[s] & b_mm_resolve) != {B_W{1'b0}})) pend_now_s[s] = 1'b0;
      else pend_now_s[s] = pend_now_s[s];
    end
    for (int k = 0; k < NUM_BR_IN; k++) begin
      mask_v = br_in_b_mask[k*B_W +: B_W];
      slot_v = br_in_valid[k] ? br_in_b_mm[k*B_W +: B_W] : {B_W{1'b0}};
      clash_s      = clash_s | ((seen_slots_s & slot_v) != {B_W{1'b0}});
      seen_slots_s = seen_slots_s | slot_v;
      if (!(b_mm_mispred && ((mask_v & b_mm_resolve) != {B_W{1'b0}}))) begin
        acc_slots_s = acc_slots_s | slot_v;
        for (int s = 0; s < B_W; s++) begin
          if (slot_v[s]) dep_d[s] = b_mm_mispred ? mask_v : (mask_v & ~b_mm_resolve);
          else dep_d[s] = dep_d[s];
        end
      end else begin
        acc_slots_s = acc_slots_s;
      end
    end
    live_d = pend_now_s | acc_slots_s;
  end

  // shadow state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_q <= {B_W{1'b0}};
      for (int s = 0; s < B_W; s++) dep_q[s] <= {B_W{1'b0}};
    end else begin
      live_q <= live_d;
      dep_q  <= dep_d;
    end
  end

  a_mispred_onehot: assert property (@(posedge clock) disable iff (reset)
    b_mm_mispred |-> $onehot(b_mm_resolve));

  a_no_squashed_broadcast: assert property (@(posedge clock) disable iff (reset)
    (b_mm_resolve & ~live_q) == {B_W{1'b0}});

  a_no_pending_reuse: assert property (@(posedge clock) disable iff (reset)
    (acc_slots_s & pend_now_s) == {B_W{1'b0}});

  a_no_same_slot_inputs: assert property (@(posedge clock) disable iff (reset)
    !clash_s);

endmodule

// File: rtl/branch_resolver.sv
// Collects resolved branch results and broadcasts at most one resolution per cycle,
// oldest mispredict first, never broadcasting a branch squashed by an older one.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int NUM_BR_IN = NUM_BR_IN_DEF,
  parameter int B_W       = B_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_BR_IN-1:0]        br_in_valid,
  input  logic [NUM_BR_IN*B_W-1:0]    br_in_b_mm,
  input  logic [NUM_BR_IN*B_W-1:0]    br_in_b_mask,
  input  logic [NUM_BR_IN-1:0]        br_in_mispred,
  input  logic [NUM_BR_IN*ADDR_W-1:0] br_in_target,
  output logic [B_W-1:0]              b_mm_resolve,
  output logic                        b_mm_mispred,
  output logic [ADDR_W-1:0]           resolve_target
);

  logic [B_W-1:0]    pend_v_q, pend_v_d;
  logic [B_W-1:0]    pend_mp_q, pend_mp_d;
  logic [B_W-1:0]    pend_dep_q [B_W];
  logic [B_W-1:0]    pend_dep_d [B_W];
  logic [ADDR_W-1:0] pend_tgt_q [B_W];
  logic [ADDR_W-1:0] pend_tgt_d [B_W];

  logic [B_W-1:0]    resolve_q, resolve_d;
  logic              mispred_q, mispred_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic [NUM_BR_IN-1:0] in_ok_s;
  logic [B_W-1:0]       in_dep_s [NUM_BR_IN];

  logic [B_W-1:0]       cand_v_s, cand_mp_s;
  logic [B_W-1:0]       cand_dep_s [B_W];
  logic [ADDR_W-1:0]    cand_tgt_s [B_W];
  logic [B_W*B_W-1:0]   cand_dep_flat_s;
  logic [B_W-1:0]       oldest_s;
  logic                 found_s;

  // squashed producers are dropped; correctly resolved bits leave incoming masks
  always_comb begin
    for (int k = 0; k < NUM_BR_IN; k++) begin
      in_dep_s[k] = br_in_b_mask[k*B_W +: B_W];
      in_ok_s[k]  = br_in_valid[k];
      if (mispred_q) begin
        if ((in_dep_s[k] & resolve_q) != {B_W{1'b0}}) in_ok_s[k] = 1'b0;
        else in_ok_s[k] = br_in_valid[k];
      end else begin
        in_dep_s[k] = in_dep_s[k] & ~resolve_q;
      end
    end
  end

  // merge pending entries and accepted inputs into one per-slot candidate view
  always_comb begin
    cand_v_s        = pend_v_q;
    cand_mp_s       = pend_mp_q;
    cand_dep_s      = pend_dep_q;
    cand_tgt_s      = pend_tgt_q;
    cand_dep_flat_s = {(B_W*B_W){1'b0}};
    for (int k = 0; k < NUM_BR_IN; k++) begin
      for (int s = 0; s < B_W; s++) begin
        if (in_ok_s[k] && br_in_b_mm[k*B_W + s]) begin
          cand_v_s[s]   = 1'b1;
          cand_mp_s[s]  = br_in_mispred[k];
          cand_dep_s[s] = in_dep_s[k];
          cand_tgt_s[s] = br_in_target[k*ADDR_W +: ADDR_W];
        end else begin
          cand_v_s[s] = cand_v_s[s];
        end
      end
    end
    for (int s = 0; s < B_W; s++) cand_dep_flat_s[s*B_W +: B_W] = cand_dep_s[s];
  end

  br_oldest_sel #(
    .B_W (B_W)
  ) u_oldest_sel (
    .mp_i     (cand_v_s & cand_mp_s),
    .dep_i    (cand_dep_flat_s),
    .oldest_o (oldest_s),
    .found_o  (found_s)
  );

  // choose this cycle's broadcast and update the pending table
  always_comb begin
    resolve_d  = {B_W{1'b0}};
    mispred_d  = 1'b0;
    tgt_d      = {ADDR_W{1'b0}};
    pend_v_d   = cand_v_s;
    pend_mp_d  = cand_mp_s;
    pend_dep_d = cand_dep_s;
    pend_tgt_d = cand_tgt_s;
    if (found_s) begin
      resolve_d = oldest_s;
      mispred_d = 1'b1;
      for (int s = 0; s < B_W; s++) begin
        tgt_d       = tgt_d | (cand_tgt_s[s] & {ADDR_W{oldest_s[s]}});
        // the winner and everything younger than it leave the table
        pend_v_d[s] = cand_v_s[s] & ~oldest_s[s] &
                      ((cand_dep_s[s] & oldest_s) == {B_W{1'b0}});
      end
    end else if (cand_v_s != {B_W{1'b0}}) begin
      resolve_d = cand_v_s;
      pend_v_d  = {B_W{1'b0}};
      for (int s = 0; s < B_W; s++) pend_dep_d[s] = cand_dep_s[s] & ~cand_v_s;
    end else begin
      resolve_d = {B_W{1'b0}};
    end
  end

  // table and broadcast registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_v_q  <= {B_W{1'b0}};
      pend_mp_q <= {B_W{1'b0}};
      for (int s = 0; s < B_W; s++) begin
        pend_dep_q[s] <= {B_W{1'b0}};
        pend_tgt_q[s] <= {ADDR_W{1'b0}};
      end
      resolve_q <= {B_W{1'b0}};
      mispred_q <= 1'b0;
      tgt_q     <= {ADDR_W{1'b0}};
    end else begin
      pend_v_q   <= pend_v_d;
      pend_mp_q  <= pend_mp_d;
      pend_dep_q <= pend_dep_d;
      pend_tgt_q <= pend_tgt_d;
      resolve_q  <= resolve_d;
      mispred_q  <= mispred_d;
      tgt_q      <= tgt_d;
    end
  end

  assign b_mm_resolve   = resolve_q;
  assign b_mm_mispred   = mispred_q;
  assign resolve_target = tgt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with B_W=4, NUM_BR_IN=2 and hand-computed expectations.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  br_in_valid;
  logic [7:0]  br_in_b_mm;
  logic [7:0]  br_in_b_mask;
  logic [1:0]  br_in_mispred;
  logic [63:0] br_in_target;
  logic [3:0]  b_mm_resolve;
  logic        b_mm_mispred;
  logic [31:0] resolve_target;

  int errors = 0;
  int checks = 0;

  branch_resolver #(.NUM_BR_IN(2), .B_W(4), .ADDR_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .br_in_valid    (br_in_valid),
    .br_in_b_mm     (br_in_b_mm),
    .br_in_b_mask   (br_in_b_mask),
    .br_in_mispred  (br_in_mispred),
    .br_in_target   (br_in_target),
    .b_mm_resolve   (b_mm_resolve),
    .b_mm_mispred   (b_mm_mispred),
    .resolve_target (resolve_target)
  );

  branch_resolver_sva #(.NUM_BR_IN(2), .B_W(4)) u_sva (
    .clock        (clock),
    .reset        (reset),
    .br_in_valid  (br_in_valid),
    .br_in_b_mm   (br_in_b_mm),
    .br_in_b_mask (br_in_b_mask),
    .b_mm_resolve (b_mm_resolve),
    .b_mm_mispred (b_mm_mispred)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input int k, input br_result_t r);
    br_in_valid[k]           = r.valid;
    br_in_b_mm[k*4 +: 4]     = r.b_mm;
    br_in_b_mask[k*4 +: 4]   = r.b_mask;
    br_in_mispred[k]         = r.mispred;
    br_in_target[k*32 +: 32] = r.target;
  endtask

  task automatic idle_inputs();
    br_in_valid   = 2'b00;
    br_in_b_mm    = 8'h00;
    br_in_b_mask  = 8'h00;
    br_in_mispred = 2'b00;
    br_in_target  = 64'h0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] er, input logic em, input logic [31:0] et);
    checks++;
    assert (b_mm_resolve === er) else begin
      errors++;
      $error("FAIL %s resolve: got %b want %b", tag, b_mm_resolve, er);
    end
    checks++;
    assert (b_mm_mispred === em) else begin
      errors++;
      $error("FAIL %s mispred: got %b want %b", tag, b_mm_mispred, em);
    end
    checks++;
    assert (resolve_target === et) else begin
      errors++;
      $error("FAIL %s target: got %h want %h", tag, resolve_target, et);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("reset", 4'b0000, 1'b0, 32'h0);
    reset = 1'b0;
    tick();
    chk("post_reset_idle", 4'b0000, 1'b0, 32'h0);

    // single correct branch
    drive(0, '{1'b1, 4'b0010, 4'b0001, 1'b0, 32'h0000_0055});
    tick();
    chk("single_correct", 4'b0010, 1'b0, 32'h0);
    idle_inputs();
    tick();
    chk("single_correct_hold", 4'b0000, 1'b0, 32'h0);

    // two correct branches in one cycle
    drive(0, '{1'b1, 4'b0001, 4'b0000, 1'b0, 32'h0});
    drive(1, '{1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0});
    tick();
    chk("two_correct", 4'b0101, 1'b0, 32'h0);
    idle_inputs();
    tick();
    chk("two_correct_hold", 4'b0000, 1'b0, 32'h0);

    // two dependent mispredicts: only the older one is broadcast
    drive(0, '{1'b1, 4'b0001, 4'b0000, 1'b1, 32'h0000_0100});
    drive(1, '{1'b1, 4'b0010, 4'b0001, 1'b1, 32'h0000_0200});
    tick();
    chk("mp_oldest", 4'b0001, 1'b1, 32'h0000_0100);
    idle_inputs();
    tick();
    chk("mp_younger_squashed", 4'b0000, 1'b0, 32'h0);
    tick();
    chk("mp_younger_never", 4'b0000, 1'b0, 32'h0);

    // independent correct waits behind a mispredict
    drive(0, '{1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0});
    drive(1, '{1'b1, 4'b0001, 4'b0000, 1'b1, 32'h0000_0040});
    tick();
    chk("mp_first", 4'b0001, 1'b1, 32'h0000_0040);
    idle_inputs();
    tick();
    chk("delayed_correct", 4'b0100, 1'b0, 32'h0);
    tick();
    chk("delayed_correct_hold", 4'b0000, 1'b0, 32'h0);

    // input depending on the slot being mispredicted is dropped
    drive(0, '{1'b1, 4'b0001, 4'b0000, 1'b1, 32'h0000_0080});
    tick();
    chk("drop_setup", 4'b0001, 1'b1, 32'h0000_0080);
    idle_inputs();
    drive(0, '{1'b1, 4'b1000, 4'b0001, 1'b0, 32'h0});
    tick();
    chk("dropped_input", 4'b0000, 1'b0, 32'h0);
    idle_inputs();
    tick();

    // after a correct broadcast, its bit is stripped from new masks
    drive(0, '{1'b1, 4'b0001, 4'b0000, 1'b0, 32'h0});
    tick();
    chk("strip_setup", 4'b0001, 1'b0, 32'h0);
    drive(0, '{1'b1, 4'b0010, 4'b0001, 1'b1, 32'h0000_0300});
    tick();
    chk("strip_kept", 4'b0010, 1'b1, 32'h0000_0300);
    idle_inputs();
    tick();
    chk("strip_hold", 4'b0000, 1'b0, 32'h0);

    // dependent correct branch dies with its mispredicted ancestor
    drive(0, '{1'b1, 4'b0100, 4'b0001, 1'b0, 32'h0});
    drive(1, '{1'b1, 4'b0001, 4'b0000, 1'b1, 32'h0000_0010});
    tick();
    chk("dep_correct_mp", 4'b0001, 1'b1, 32'h0000_0010);
    idle_inputs();
    tick();
    chk("dep_correct_killed", 4'b0000, 1'b0, 32'h0);

    // pending correct waits through two successive mispredicts
    drive(0, '{1'b1, 4'b0001, 4'b0000, 1'b1, 32'h0000_0010});
    drive(1, '{1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0});
    tick();
    chk("chain_mp1", 4'b0001, 1'b1, 32'h0000_0010);
    idle_inputs();
    drive(0, '{1'b1, 4'b0010, 4'b0100, 1'b1, 32'h0000_0020});
    tick();
    chk("chain_mp2", 4'b0010, 1'b1, 32'h0000_0020);
    idle_inputs();
    tick();
    chk("chain_correct", 4'b0100, 1'b0, 32'h0);

    // reset mid-cycle with a pending entry in the table
    tick();
    drive(0, '{1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0});
    drive(1, '{1'b1, 4'b0001, 4'b0000, 1'b1, 32'h0000_0040});
    tick();
    chk("pre_reset", 4'b0001, 1'b1, 32'h0000_0040);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk("reset_async", 4'b0000, 1'b0, 32'h0);
    #1 reset = 1'b0;
    tick();
    chk("reset_lost1", 4'b0000, 1'b0, 32'h0);
    tick();
    chk("reset_lost2", 4'b0000, 1'b0, 32'h0);
    drive(0, '{1'b1, 4'b1000, 4'b0000, 1'b0, 32'h0});
    tick();
    chk("after_reset_new", 4'b1000, 1'b0, 32'h0);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
